fwpayload_sram_arbiter: RTL and testbench

// - Shares the single-port payload SRAM (32 x 2^ADR_BITS words) between N_PORTS Wishbone-classic targets.
// - Replaces the fixed 4-cycle WB-to-SRAM bridge with three features:
//   - round-robin arbitration;
//   - a programmable number of wait states;
//   - a clean abort when an initiator drops cyc.
// - Port 0 is normally fed by the interconnect SRAM target. Port 1 is the direct mgmt/LA path used for firmware load.
//

---
 rtl/fwpayload_sram_arbiter_if.sv | 39 +++
 rtl/fwpayload_sram_arbiter.sv | 138 +++++++++++++
 tb/tb_fwpayload_sram_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwpayload_sram_arbiter_if.sv
// Bus bundle between the Wishbone initiators, the payload SRAM and the arbiter.
// Per-port fields are packed arrays indexed by port number.
interface fwpayload_sram_arbiter_if #(
   parameter int N_PORTS  = 2,
   parameter int ADR_BITS = 8
) ();
   logic [N_PORTS-1:0][31:0] p_adr;
   logic [N_PORTS-1:0][31:0] p_dat_w;
   logic [N_PORTS-1:0][31:0] p_dat_r;
   logic [N_PORTS-1:0][3:0]  p_sel;
   logic [N_PORTS-1:0]       p_we;
   logic [N_PORTS-1:0]       p_cyc;
   logic [N_PORTS-1:0]       p_stb;
   logic [N_PORTS-1:0]       p_ack;
   logic [N_PORTS-1:0]       p_err;

   logic                     sram_en;
   logic                     sram_we;
   logic [3:0]               sram_sel;
   logic [ADR_BITS-1:0]      sram_adr;
   logic [31:0]              sram_dat_w;
   logic [31:0]              sram_dat_r;

   // Arbiter side: WB target towards the ports, controller towards the SRAM.
   modport slave (
      input  p_adr, p_dat_w, p_sel, p_we, p_cyc, p_stb,
      output p_dat_r, p_ack, p_err,
      output sram_en, sram_we, sram_sel, sram_adr, sram_dat_w,
      input  sram_dat_r
   );

   // Initiators plus SRAM macro side.
   modport master (
      output p_adr, p_dat_w, p_sel, p_we, p_cyc, p_stb,
      input  p_dat_r, p_ack, p_err,
      input  sram_en, sram_we, sram_sel, sram_adr, sram_dat_w,
      output sram_dat_r
   );
endinterface

// File: rtl/fwpayload_sram_arbiter.sv
// Round-robin arbiter sharing one single-port payload SRAM among N_PORTS
// Wishbone-classic targets, with programmable wait states and cyc-drop abort.
module fwpayload_sram_arbiter #(
   parameter int N_PORTS     = 2,
   parameter int ADR_BITS    = 8,
   parameter int WAIT_STATES = 0
) (
   input  logic                     clock,
   input  logic                     reset_n,
   fwpayload_sram_arbiter_if.slave  bus,
   output logic [N_PORTS-1:0]       grant,
   output logic                     busy
);
   localparam int LW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_e;

   state_e             state_q, state_d;
   logic [N_PORTS-1:0] grant_q, grant_d;
   logic [LW-1:0]      last_q, last_d;
   logic [3:0]         cnt_q, cnt_d;

   logic [N_PORTS-1:0] req;
   logic [LW-1:0]      win_idx;
   logic               win_vld;
   logic [LW-1:0]      gnt_idx;
   int                 rr_idx;
   logic               unused_adr;

   assign req = bus.p_cyc & bus.p_stb;

   // Search begins just after the most recent owner so no port can starve.
   always_comb begin
      win_idx = '0;
      win_vld = 1'b0;
      rr_idx  = 0;
      for (int i = 1; i <= N_PORTS; i++) begin
         rr_idx = (int'(last_q) + i) % N_PORTS;
         if (!win_vld && req[LW'(rr_idx)]) begin
            win_idx = LW'(rr_idx);
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_idx = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (grant_q[k]) gnt_idx = LW'(k);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LW'(N_PORTS - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d = ACCESS;
               grant_d = {{(N_PORTS-1){1'b0}}, 1'b1} << win_idx;
               cnt_d   = 4'(WAIT_STATES);
            end
         end
         ACCESS: begin
            // Initiator gave up: release the SRAM without acking.
            if (!bus.p_cyc[gnt_idx]) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = gnt_idx;
               cnt_d   = '0;
            end else if (cnt_q == 4'd0) begin
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK: begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = gnt_idx;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_comb begin
      bus.sram_en    = (state_q == ACCESS);
      bus.sram_we    = 1'b0;
      bus.sram_sel   = '0;
      bus.sram_adr   = '0;
      bus.sram_dat_w = '0;
      if (state_q == ACCESS) begin
         bus.sram_we    = bus.p_we[gnt_idx];
         bus.sram_sel   = bus.p_sel[gnt_idx];
         bus.sram_adr   = bus.p_adr[gnt_idx][ADR_BITS+1:2];
         bus.sram_dat_w = bus.p_dat_w[gnt_idx];
      end
      // SRAM read data lands during ACK, one cycle after the last enable.
      bus.p_ack   = '0;
      bus.p_dat_r = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (state_q == ACK && grant_q[k]) begin
            bus.p_ack[k]   = 1'b1;
            bus.p_dat_r[k] = bus.sram_dat_r;
         end
      end
      bus.p_err = '0;
      grant     = grant_q;
      busy      = (state_q != IDLE);
   end

   // Address bits outside the SRAM word range alias and are ignored.
   always_comb begin
      unused_adr = 1'b0;
      for (int k = 0; k < N_PORTS; k++) begin
         unused_adr = unused_adr ^ (^bus.p_adr[k][31:ADR_BITS+2]) ^ (^bus.p_adr[k][1:0]);
      end
   end
endmodule

// File: tb/tb_fwpayload_sram_arbiter.sv
// Directed bench: three arbiter builds (2 ports/0 ws, 2 ports/3 ws, 4 ports/5 ws)
// each with a small behavioural SRAM.
module tb_fwpayload_sram_arbiter;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   fwpayload_sram_arbiter_if #(.N_PORTS(2), .ADR_BITS(8)) ifa ();
   fwpayload_sram_arbiter_if #(.N_PORTS(2), .ADR_BITS(8)) ifb ();
   fwpayload_sram_arbiter_if #(.N_PORTS(4), .ADR_BITS(8)) ifc ();

   logic [1:0] grant_a, grant_b;
   logic [3:0] grant_c;
   logic       busy_a, busy_b, busy_c;

   fwpayload_sram_arbiter #(.N_PORTS(2), .ADR_BITS(8), .WAIT_STATES(0)) dut_a (
      .clock(clock), .reset_n(reset_n), .bus(ifa.slave), .grant(grant_a), .busy(busy_a));
   fwpayload_sram_arbiter #(.N_PORTS(2), .ADR_BITS(8), .WAIT_STATES(3)) dut_b (
      .clock(clock), .reset_n(reset_n), .bus(ifb.slave), .grant(grant_b), .busy(busy_b));
   fwpayload_sram_arbiter #(.N_PORTS(4), .ADR_BITS(8), .WAIT_STATES(5)) dut_c (
      .clock(clock), .reset_n(reset_n), .bus(ifc.slave), .grant(grant_c), .busy(busy_c));

   // Unwritten words read back a fixed pattern per address.
   function automatic logic [31:0] init_word(input logic [7:0] a);
      case (a)
         8'd4:    return 32'hDEAD_BEEF;
         8'd8:    return 32'hAAAA_AAAA;
         default: return {24'hC0DE00, a};
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = cur;
      for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];
   logic [31:0] mem_c [256];
   bit          wr_a [256];
   bit          wr_b [256];
   bit          wr_c [256];

   always @(posedge clock) begin
      if (ifa.sram_en) begin
         if (ifa.sram_we) begin
            mem_a[ifa.sram_adr] <= merge(wr_a[ifa.sram_adr] ? mem_a[ifa.sram_adr] : init_word(ifa.sram_adr),
                                         ifa.sram_dat_w, ifa.sram_sel);
            wr_a[ifa.sram_adr]  <= 1'b1;
         end else begin
            ifa.sram_dat_r <= wr_a[ifa.sram_adr] ? mem_a[ifa.sram_adr] : init_word(ifa.sram_adr);
         end
      end
      if (ifb.sram_en) begin
         if (ifb.sram_we) begin
            mem_b[ifb.sram_adr] <= merge(wr_b[ifb.sram_adr] ? mem_b[ifb.sram_adr] : init_word(ifb.sram_adr),
                                         ifb.sram_dat_w, ifb.sram_sel);
            wr_b[ifb.sram_adr]  <= 1'b1;
         end else begin
            ifb.sram_dat_r <= wr_b[ifb.sram_adr] ? mem_b[ifb.sram_adr] : init_word(ifb.sram_adr);
         end
      end
      if (ifc.sram_en) begin
         if (ifc.sram_we) begin
            mem_c[ifc.sram_adr] <= merge(wr_c[ifc.sram_adr] ? mem_c[ifc.sram_adr] : init_word(ifc.sram_adr),
                                         ifc.sram_dat_w, ifc.sram_sel);
            wr_c[ifc.sram_adr]  <= 1'b1;
         end else begin
            ifc.sram_dat_r <= wr_c[ifc.sram_adr] ? mem_c[ifc.sram_adr] : init_word(ifc.sram_adr);
         end
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int          lat;
   int          got;
   logic [3:0]  seq [5];
   logic [3:0]  exp6b [4];
   logic [1:0]  gexp;
   logic        ack0_seen;

   initial begin
      ifa.p_adr = '0; ifa.p_dat_w = '0; ifa.p_sel = '0; ifa.p_we = '0; ifa.p_cyc = '0; ifa.p_stb = '0;
      ifb.p_adr = '0; ifb.p_dat_w = '0; ifb.p_sel = '0; ifb.p_we = '0; ifb.p_cyc = '0; ifb.p_stb = '0;
      ifc.p_adr = '0; ifc.p_dat_w = '0; ifc.p_sel = '0; ifc.p_we = '0; ifc.p_cyc = '0; ifc.p_stb = '0;
      exp6b[0] = 4'b0001; exp6b[1] = 4'b0010; exp6b[2] = 4'b1000; exp6b[3] = 4'b0001;

      // Reset state
      reset_n = 1'b0;
      repeat (3) tick();
      check("rst_busy",  {busy_a, busy_b, busy_c}, 0);
      check("rst_grant", {grant_a, grant_b, grant_c}, 0);
      check("rst_en",    {ifa.sram_en, ifb.sram_en, ifc.sram_en}, 0);
      check("rst_ack",   {ifa.p_ack, ifb.p_ack, ifc.p_ack}, 0);
      check("rst_err",   {ifa.p_err, ifb.p_err, ifc.p_err}, 0);
      reset_n = 1'b1;
      tick();

      // 1: single read, zero wait states
      ifa.p_adr[0] = 32'h0000_0010; ifa.p_sel[0] = 4'hF; ifa.p_we[0] = 1'b0;
      ifa.p_cyc[0] = 1'b1; ifa.p_stb[0] = 1'b1;
      #1;
      check("t1_idle_en",  ifa.sram_en, 0);
      check("t1_idle_adr", ifa.sram_adr, 0);
      tick();
      check("t1_en",    ifa.sram_en, 1);
      check("t1_adr",   ifa.sram_adr, 4);
      check("t1_we",    ifa.sram_we, 0);
      check("t1_grant", grant_a, 2'b01);
      check("t1_early_ack", ifa.p_ack, 0);
      tick();
      check("t1_ack",    ifa.p_ack, 2'b01);
      check("t1_dat",    ifa.p_dat_r[0], 32'hDEAD_BEEF);
      check("t1_dat_p1", ifa.p_dat_r[1], 0);
      check("t1_en_off", ifa.sram_en, 0);
      check("t1_adr_off", ifa.sram_adr, 0);
      ifa.p_cyc[0] = 1'b0; ifa.p_stb[0] = 1'b0;
      tick();
      check("t1_ack_pulse", ifa.p_ack, 0);
      check("t1_busy_off",  busy_a, 0);

      // 2: partial write with three wait states, then read it back
      ifb.p_adr[1] = 32'h0000_0020; ifb.p_dat_w[1] = 32'h1234_5678; ifb.p_sel[1] = 4'b0011;
      ifb.p_we[1] = 1'b1; ifb.p_cyc[1] = 1'b1; ifb.p_stb[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t2_en",    ifb.sram_en, 1);
         check("t2_ctl",   {ifb.sram_we, ifb.sram_sel, ifb.sram_adr}, {1'b1, 4'b0011, 8'd8});
         check("t2_dat_w", ifb.sram_dat_w, 32'h1234_5678);
         check("t2_noack", ifb.p_ack, 0);
      end
      tick();
      check("t2_ack",    ifb.p_ack, 2'b10);
      check("t2_en_off", ifb.sram_en, 0);
      ifb.p_cyc[1] = 1'b0; ifb.p_stb[1] = 1'b0; ifb.p_we[1] = 1'b0;
      tick();
      ifb.p_sel[1] = 4'hF; ifb.p_cyc[1] = 1'b1; ifb.p_stb[1] = 1'b1;
      lat = 0;
      do begin tick(); lat++; end while (ifb.p_ack[1] !== 1'b1 && lat < 20);
      check("t2_rd_lat", lat, 5);
      check("t2_rd_dat", ifb.p_dat_r[1], 32'hAAAA_5678);
      ifb.p_cyc[1] = 1'b0; ifb.p_stb[1] = 1'b0;
      tick();

      // 3: continuous contention from reset alternates owners
      reset_n = 1'b0;
      ifa.p_adr[0] = 32'h10; ifa.p_adr[1] = 32'h20; ifa.p_we = '0; ifa.p_sel = '1;
      ifa.p_cyc = 2'b11; ifa.p_stb = 2'b11;
      tick();
      reset_n = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         gexp = (i % 3 == 0) ? 2'b00 : ((((i - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10);
         check("t3_gnt_ack", {grant_a, ifa.p_ack}, {gexp, (i % 3 == 2) ? gexp : 2'b00});
         if (i % 3 == 2)
            check("t3_dat", {ifa.p_dat_r[1], ifa.p_dat_r[0]},
                  (gexp == 2'b01) ? {32'h0, 32'hDEAD_BEEF} : {32'hAAAA_AAAA, 32'h0});
      end
      ifa.p_cyc = '0; ifa.p_stb = '0;
      tick();

      // 5: reset during ACCESS after port 0 was last owner
      ifb.p_adr[0] = 32'h10; ifb.p_sel[0] = 4'hF; ifb.p_we = '0;
      ifb.p_cyc[0] = 1'b1; ifb.p_stb[0] = 1'b1;
      lat = 0;
      do begin tick(); lat++; end while (ifb.p_ack[0] !== 1'b1 && lat < 20);
      check("t5_pre_ack", ifb.p_ack, 2'b01);
      ifb.p_cyc[0] = 1'b0; ifb.p_stb[0] = 1'b0;
      tick();
      ifb.p_cyc[1] = 1'b1; ifb.p_stb[1] = 1'b1;
      tick(); tick();
      check("t5_mid", {busy_b, grant_b}, {1'b1, 2'b10});
      reset_n = 1'b0;
      ifb.p_cyc[0] = 1'b1; ifb.p_stb[0] = 1'b1;
      tick();
      check("t5_rst", {ifb.sram_en, grant_b, ifb.p_ack, busy_b}, 0);
      reset_n = 1'b1;
      tick();
      check("t5_first", grant_b, 2'b01);
      ifb.p_cyc = '0; ifb.p_stb = '0;
      tick();
      check("t5_drop_idle", {busy_b, ifb.p_ack}, 0);

      // 4: abort on cyc drop, pending port then served
      ifc.p_sel = '1; ifc.p_we = '0;
      ifc.p_cyc = 4'b0011; ifc.p_stb = 4'b0011;
      tick();
      check("t4_gnt0", grant_c, 4'b0001);
      tick();
      check("t4_busy", busy_c, 1);
      ifc.p_cyc[0] = 1'b0;
      tick();
      check("t4_abort", {busy_c, grant_c, ifc.p_ack}, 0);
      tick();
      check("t4_gnt1", grant_c, 4'b0010);
      lat = 0; ack0_seen = 1'b0;
      do begin
         tick(); lat++;
         if (ifc.p_ack[0]) ack0_seen = 1'b1;
      end while (ifc.p_ack[1] !== 1'b1 && lat < 30);
      check("t4_lat", lat, 6);
      check("t4_ack", ifc.p_ack, 4'b0010);
      check("t4_no_ack0", ack0_seen, 0);
      ifc.p_cyc = '0; ifc.p_stb = '0;
      tick();

      // 6: four-port rotation from reset
      reset_n = 1'b0;
      ifc.p_cyc = 4'b1111; ifc.p_stb = 4'b1111;
      tick();
      reset_n = 1'b1;
      got = 0; lat = 0;
      while (got < 5 && lat < 200) begin
         tick(); lat++;
         if (ifc.p_ack != 4'b0000) begin seq[got] = ifc.p_ack; got++; end
      end
      check("t6_cnt", got, 5);
      for (int i = 0; i < 5; i++) check("t6_seq", seq[i], 4'b0001 << (i % 4));

      // 6b: idle port 2 is skipped
      reset_n = 1'b0;
      ifc.p_cyc = 4'b1011; ifc.p_stb = 4'b1011;
      tick();
      reset_n = 1'b1;
      got = 0; lat = 0;
      while (got < 4 && lat < 200) begin
         tick(); lat++;
         if (ifc.p_ack != 4'b0000) begin seq[got] = ifc.p_ack; got++; end
      end
      check("t6b_cnt", got, 4);
      for (int i = 0; i < 4; i++) check("t6b_seq", seq[i], exp6b[i]);
      ifc.p_cyc = '0; ifc.p_stb = '0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
